// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs
// for the WISC-15 interlock, with decoder-side and sequencer-side views.
interface hazard_ctrl_if;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        ex_load;
  logic [3:0]  ex_rd;
  logic        ex_redirect;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        halted;
  logic [15:0] stall_cycles;
  logic [1:0]  state;

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt,
    input  ex_load, ex_rd, ex_redirect,
    output pc_stall, if_id_stall, if_id_flush,
    output id_ex_flush, halted, stall_cycles, state
  );

  modport master (
    output id_valid, id_opcode, id_rs, id_rt,
    output ex_load, ex_rd, ex_redirect,
    input  pc_stall, if_id_stall, if_id_flush,
    input  id_ex_flush, halted, stall_cycles, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use interlock, redirect squash and hlt drain
// sequencer for the WISC-15 five-stage pipeline.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        halted_q, halted_d;

  logic rs_use, rt_use, r15_use;
  logic src_hit, lu, is_hlt;
  logic pc_stall_c, if_id_stall_c;
  logic if_id_flush_c, id_ex_flush_c;

  always_comb begin
    rs_use  = (bus.id_opcode <= 4'hA);
    rt_use  = (bus.id_opcode <= 4'h4)
           || (bus.id_opcode == 4'h9);
    r15_use = (bus.id_opcode == 4'hE);
    src_hit = (rs_use  && bus.ex_rd == bus.id_rs)
           || (rt_use  && bus.ex_rd == bus.id_rt)
           || (r15_use && bus.ex_rd == 4'hF);
    lu      = (state_q == RUN) && bus.id_valid
           && bus.ex_load && (bus.ex_rd != 4'h0)
           && src_hit;
    is_hlt  = bus.id_valid && (bus.id_opcode == 4'hF);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_d       = stall_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    unique case (state_q)
      RUN: begin
        // Redirect squashes the ID instruction, so it hides lu and hlt.
        if (bus.ex_redirect) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (lu) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          if (stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
        end else if (is_hlt) begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
          cnt_d         = 4'(DRAIN_CYCLES);
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        pc_stall_c    = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        cnt_d         = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = HALTED;
      end
      HALTED: begin
        pc_stall_c    = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 4'd0;
      stall_q  <= 16'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
    end
  end

  // Gate with rst so outputs drop before any clock edge.
  assign bus.pc_stall     = pc_stall_c    & ~rst;
  assign bus.if_id_stall  = if_id_stall_c & ~rst;
  assign bus.if_id_flush  = if_id_flush_c & ~rst;
  assign bus.id_ex_flush  = id_ex_flush_c & ~rst;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl
// against a cycle-indexed behavioural model of the interlock rules.
module tb_hazard_ctrl;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int halt_t = -1;
  int m_stalls = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(logic [3:0] op, logic [3:0] r,
                               logic [3:0] rs, logic [3:0] rt);
    bit hit;
    hit = 1'b0;
    if (int'(op) <= 10 && r == rs) hit = 1'b1;
    if ((int'(op) <= 4 || op == 4'd9) && r == rt) hit = 1'b1;
    if (op == 4'd14 && r == 4'd15) hit = 1'b1;
    return hit;
  endfunction

  function automatic int mode_now();
    if (halt_t < 0 || cyc <= halt_t) return 0;
    if (cyc <= halt_t + D) return 1;
    return 2;
  endfunction

  task automatic drive(bit v, int op, int rs, int rt,
                       bit ld, int rd, bit rdr);
    bus.id_valid    = v;
    bus.id_opcode   = 4'(op);
    bus.id_rs       = 4'(rs);
    bus.id_rt       = 4'(rt);
    bus.ex_load     = ld;
    bus.ex_rd       = 4'(rd);
    bus.ex_redirect = rdr;
  endtask

  // Check the current cycle, then advance one clock.
  task automatic step(string tag);
    int  m;
    bit  e_pc, e_stl, e_iff, e_ief, is_lu, take_h;
    m = mode_now();
    e_pc = 0; e_stl = 0; e_iff = 0; e_ief = 0;
    is_lu = 0; take_h = 0;
    if (m == 0) begin
      if (bus.ex_redirect) begin
        e_iff = 1; e_ief = 1;
      end else if (bus.id_valid && bus.ex_load && bus.ex_rd != 0
                   && reads(bus.id_opcode, bus.ex_rd,
                            bus.id_rs, bus.id_rt)) begin
        e_pc = 1; e_stl = 1; e_ief = 1; is_lu = 1;
      end else if (bus.id_valid && bus.id_opcode == 4'd15) begin
        e_pc = 1; e_iff = 1; take_h = 1;
      end
    end else begin
      e_pc = 1; e_iff = 1; e_ief = 1;
    end
    #1;
    chk({tag, ".pc_stall"}, 32'(bus.pc_stall), 32'(e_pc));
    chk({tag, ".if_id_stall"}, 32'(bus.if_id_stall), 32'(e_stl));
    chk({tag, ".if_id_flush"}, 32'(bus.if_id_flush), 32'(e_iff));
    chk({tag, ".id_ex_flush"}, 32'(bus.id_ex_flush), 32'(e_ief));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m == 2));
    chk({tag, ".state"}, 32'(bus.state), 32'(m));
    chk({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(m_stalls));
    @(posedge clk);
    if (is_lu && m_stalls < 65535) m_stalls++;
    if (take_h) halt_t = cyc;
    cyc++;
    @(negedge clk);
  endtask

  // Raise rst between edges; outputs must clear without a clock.
  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".pc_stall"}, 32'(bus.pc_stall), 0);
    chk({tag, ".if_id_stall"}, 32'(bus.if_id_stall), 0);
    chk({tag, ".if_id_flush"}, 32'(bus.if_id_flush), 0);
    chk({tag, ".id_ex_flush"}, 32'(bus.id_ex_flush), 0);
    chk({tag, ".halted"}, 32'(bus.halted), 0);
    chk({tag, ".state"}, 32'(bus.state), 0);
    chk({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 0);
    halt_t = -1;
    m_stalls = 0;
    cyc = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset("reset");

    drive(1, 0, 5, 3, 1, 3, 0);
    step("lu_rt");
    drive(1, 0, 5, 3, 0, 3, 0);
    step("lu_rt_after");
    chk("lu_rt_count", 32'(bus.stall_cycles), 1);

    drive(1, 0, 0, 3, 1, 0, 0);
    step("no_hz_rd0");
    drive(1, 5, 7, 6, 1, 6, 0);
    step("no_hz_sll");
    drive(0, 0, 6, 6, 1, 6, 0);
    step("no_hz_invalid");

    drive(1, 14, 0, 0, 1, 15, 0);
    step("ret_lu");
    drive(1, 14, 0, 0, 1, 15, 1);
    step("ret_redirect");
    drive(1, 9, 2, 8, 1, 8, 0);
    step("sw_rt_lu");

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 14),
            $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 1), $urandom_range(0, 4),
            $urandom_range(0, 3) == 0);
      step("rand");
    end

    drive(1, 15, 0, 0, 0, 0, 1);
    step("hlt_squash");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("hlt_squash_next");

    drive(1, 15, 0, 0, 0, 0, 0);
    step("hlt_T");
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 1, 1, 1, 1, i[0]);
      step("drain");
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 15, 3, 3, 1, 3, i[0]);
      step("halted");
    end
    do_reset("reset_halted");

    drive(1, 15, 0, 0, 0, 0, 0);
    step("hlt_T2");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("drain_T1");
    do_reset("reset_mid_drain");
    step("run_after_reset");

    drive(1, 1, 4, 2, 1, 4, 0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m_stalls = 65535;
    cyc += 65540;
    chk("sat_value", 32'(bus.stall_cycles), 32'hFFFF);
    step("sat_hold");
    step("sat_hold2");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock and halt sequencer for the WISC-15 five-stage core. It sits beside the opcode decoder and watches the instruction in ID plus the instruction in EX. It generates the stall, bubble and squash signals for load-use hazards and taken control transfers (b/call/ret). It also drains the pipe after `hlt` and latches the processor halted state.

## Interface
- `DRAIN_CYCLES`, default 4: cycles spent draining after `hlt` leaves ID; legal range 1–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_valid`  in  1  IF/ID holds a real instruction (not a bubble).
- `id_opcode`  in  4  opcode of the instruction in ID (ISA encoding 0000 ADD … 1111 HLT).
- `id_rs`  in  4  first source register field in ID.
- `id_rt`  in  4  second source register field in ID.
- `ex_load`  in  1  instruction in EX is `lw` (mem_to_reg & reg_wrt).
- `ex_rd`  in  4  destination register of the instruction in EX.
- `ex_redirect`  in  1  EX resolves a taken branch, a call or a ret this cycle.
- `pc_stall`  out  1  hold the PC.
- `if_id_stall`  out  1  hold the IF/ID register.
- `if_id_flush`  out  1  load a bubble into IF/ID.
- `id_ex_flush`  out  1  load a bubble into ID/EX.
- `halted`  out  1  processor halted; sticky until reset.
- `stall_cycles`  out  16  count of load-use stall cycles, saturating.
- `state`  out  2  FSM state, for debug: RUN=0, DRAIN=1, HALTED=2.

## Operation
- Source-use decode on `id_opcode`:
  - rs is used by 0000–1010.
  - rt is used by 0000–0100 and 1001 (sw data).
  - 1110 (ret) reads R15.
  - 1011, 1100, 1101 and 1111 read no register.
- Load-use hazard (`lu`) is true when all of these hold:
  - state is RUN, `id_valid` is high and `ex_load` is high;
  - `ex_rd` is not 0;
  - `ex_rd` matches a used source (rs, rt or R15 for ret).
- The FSM is evaluated in RUN with this priority:
  1. `ex_redirect`: assert `if_id_flush` and `id_ex_flush`. Stall and hlt detection are suppressed, because the ID instruction is squashed. Stay in RUN.
  2. `lu`: assert `pc_stall`, `if_id_stall` and `id_ex_flush` for one cycle. Increment `stall_cycles`, saturating at 0xFFFF. Stay in RUN.
  3. `id_valid` and `id_opcode`==1111: assert `pc_stall` and `if_id_flush`; `hlt` itself passes into EX. Load `cnt`=`DRAIN_CYCLES` and go to DRAIN.
  4. Otherwise all control outputs are 0.
- A load-use stall re-evaluates next cycle. Because a bubble sits in EX after the stall, `lu` cannot repeat for the same instruction.
- DRAIN:
  - `pc_stall`, `if_id_flush` and `id_ex_flush` are 1; `if_id_stall` is 0.
  - `ex_redirect` and `lu` are ignored, since only older instructions remain past EX.
  - `cnt` decrements each cycle; when `cnt`==1, the next state is HALTED.
- HALTED:
  - `halted`, `pc_stall`, `if_id_flush` and `id_ex_flush` are 1.
  - All inputs are ignored; only `rst` exits.
- `stall_cycles` counts only in RUN and holds its value in DRAIN and HALTED.
- Control outputs are combinational from the registered state and the current inputs. `halted` and `stall_cycles` come directly from registers.

## Timing
- Reset (async): state goes to RUN, `cnt`=0 and `stall_cycles`=0. All outputs are 0 while `rst` is high, independent of `clk` and the inputs.
- Reset mid-DRAIN or in HALTED returns to RUN immediately. Outputs are 0 in the same cycle `rst` asserts.
- Hazard response has zero latency: outputs react in the same cycle as the inputs.
- Halt: `hlt` is in ID in cycle T with no redirect. DRAIN covers T+1 … T+`DRAIN_CYCLES`. `halted` rises in T+`DRAIN_CYCLES`+1, which is T+5 by default.
- Redirect and `hlt` in ID in the same cycle: the redirect wins and no DRAIN is entered.
- Redirect and `lu` in the same cycle: the flush wins and `stall_cycles` is unchanged.
- `stall_cycles` at 0xFFFF stays at 0xFFFF on further stalls; it does not wrap.

## Test plan
- Load-use on rt: `ex_load`=1, `ex_rd`=3; ID holds ADD (0000) with rs=5, rt=3 and `id_valid`=1.
  - Required: that cycle `pc_stall`=`if_id_stall`=`id_ex_flush`=1.
  - Next cycle with `ex_load`=0, all are 0 and `stall_cycles`=1.
- No false hazard: `ex_rd`=0, or ID is SLL (0101) with rt=`ex_rd`, or `id_valid`=0.
  - Required: all control outputs 0 and `stall_cycles` unchanged.
- Ret hazard and redirect priority:
  - `ex_load`=1, `ex_rd`=15, ID is ret (1110): stall asserted.
  - Repeat with `ex_redirect`=1: `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0, count unchanged.
- Halt drain: `hlt` in ID at cycle T.
  - Required: T has `pc_stall`=`if_id_flush`=1 and `id_ex_flush`=0.
  - T+1 to T+4: `state`=1.
  - T+5: `halted`=1 and `state`=2; it stays there for 20 cycles despite `ex_redirect` toggling.
- Halt squash: `hlt` in ID with `ex_redirect`=1.
  - Required: `state` stays 0 and `halted` stays 0.
- Async reset mid-DRAIN and saturation:
  - Assert `rst` between edges in T+2: outputs are 0 immediately and `state`=0.
  - Separately, force 65,540 stall cycles: `stall_cycles`=0xFFFF.
